// File: rtl/mul_border_ctrl.sv
// Job sequencer for one rate-coded border multiplier cell: holds an operand pair
// on the cell for 2^len cycles, counts the output bitstream and returns the result.
module mul_border_ctrl #(
  parameter int WIDTH       = 16,
  parameter int LEN_LOG_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data_i,
  input  logic [WIDTH-1:0]       in_data_w,
  input  logic [3:0]             in_len_log,
  output logic [WIDTH-1:0]       mul_data_i,
  output logic [WIDTH-1:0]       mul_data_w,
  input  logic                   mul_bit,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEN_LOG_MAX:0]   out_ones,
  output logic [LEN_LOG_MAX+1:0] out_bip,
  output logic [3:0]             out_len_log
);

  localparam int CW = LEN_LOG_MAX;
  localparam int OW = LEN_LOG_MAX + 1;
  localparam int BW = LEN_LOG_MAX + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic [BW-1:0]   bip_q, bip_d;
  logic [3:0]      len_q, len_d;
  logic [WIDTH-1:0] data_i_q, data_i_d, data_w_q, data_w_d;
  logic            busy_q, busy_d, valid_q, valid_d;

  logic [3:0]      len_clamp;
  logic [OW-1:0]   n_full;
  logic [CW-1:0]   cnt_load;
  logic [OW-1:0]   ones_inc;
  logic            in_fire;

  // rst_n gates in_ready so the scheduler never sees a ready while the block is held in reset.
  assign in_ready = rst_n & ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign in_fire  = in_valid & in_ready;

  assign len_clamp = (in_len_log > 4'(LEN_LOG_MAX)) ? 4'(LEN_LOG_MAX) : in_len_log;
  assign n_full    = OW'(1) << len_clamp;
  assign cnt_load  = CW'(n_full - OW'(1));
  assign ones_inc  = ones_q + OW'(mul_bit);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    bip_d    = bip_q;
    len_d    = len_q;
    data_i_d = data_i_q;
    data_w_d = data_w_q;
    busy_d   = busy_q;
    valid_d  = valid_q;

    case (state_q)
      RUN: begin
        ones_d = ones_inc;
        if (cnt_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          // Modulo-2^BW arithmetic lands on the right signed value since the result is within +-N.
          bip_d   = BW'({ones_inc, 1'b0}) - (BW'(1) << len_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (!in_fire && out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle result handshake in DONE chains straight into the new job.
    if (in_fire) begin
      state_d  = RUN;
      busy_d   = 1'b1;
      valid_d  = 1'b0;
      data_i_d = in_data_i;
      data_w_d = in_data_w;
      len_d    = len_clamp;
      cnt_d    = cnt_load;
      ones_d   = '0;
      bip_d    = '0;
    end

    if (flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      cnt_d   = '0;
      ones_d  = '0;
      bip_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ones_q   <= '0;
      bip_q    <= '0;
      len_q    <= '0;
      data_i_q <= '0;
      data_w_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
      bip_q    <= bip_d;
      len_q    <= len_d;
      data_i_q <= data_i_d;
      data_w_q <= data_w_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign mul_data_i  = data_i_q;
  assign mul_data_w  = data_w_q;
  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign out_ones    = ones_q;
  assign out_bip     = bip_q;
  assign out_len_log = len_q;

endmodule
